// File: rtl/iram_access_ctrl.sv
// rtl/iram_access_ctrl.sv - debug-monitor command sequencer for instruction RAM and CPU run control
//
// Purpose:
//   Accepts one monitor command at a time and turns it into instruction-RAM
//   write / read / fill sequences, steals the fetch read port while reading,
//   and starts or halts the CPU. Every accepted command yields exactly one
//   registered response strobe. RAM access is refused while the CPU runs.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only while idle)
//   cmd_op/adr/data/len        opcode, word address [31:2], data, fill count-1
//   rsp_valid/rsp_data/rsp_err one-cycle response strobe, read/PC data, reject flag
//   i_ram_wen/wadr/wdata       instruction-RAM write port
//   i_read_sel/i_ram_radr      read-port steal and read word address
//   i_ram_rdata                RAM read data, valid the cycle after the address
//   pc_data                    current fetch PC (byte address)
//   cpu_start/start_adr        one-cycle PC load strobe and load value [31:2]
//   cpu_run                    1 = CPU running, 0 stalls fetch
module iram_access_ctrl #(
    parameter int IWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [29:0]       cmd_adr,
    input  logic [31:0]       cmd_data,
    input  logic [7:0]        cmd_len,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              i_ram_wen,
    output logic [IWIDTH-2:0] i_ram_wadr,
    output logic [31:0]       i_ram_wdata,
    output logic              i_read_sel,
    output logic [IWIDTH-2:0] i_ram_radr,
    input  logic [31:0]       i_ram_rdata,
    input  logic [31:0]       pc_data,
    output logic              cpu_start,
    output logic [29:0]       start_adr,
    output logic              cpu_run
);

    localparam int AW = IWIDTH - 1;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_WRITE  = 3'd1;
    localparam logic [2:0] OP_READ   = 3'd2;
    localparam logic [2:0] OP_FILL   = 3'd3;
    localparam logic [2:0] OP_RUN    = 3'd4;
    localparam logic [2:0] OP_HALT   = 3'd5;
    localparam logic [2:0] OP_READPC = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_FILL,
        S_RD_A,
        S_RD_D,
        S_RSP
    } state_t;

    state_t          r_state;
    logic            r_cmd_ready;
    logic            r_rsp_valid;
    logic [31:0]     r_rsp_data;
    logic            r_rsp_err;
    logic            r_wen;
    logic [AW-1:0]   r_wadr;
    logic [31:0]     r_wdata;
    logic            r_read_sel;
    logic [AW-1:0]   r_radr;
    logic            r_cpu_start;
    logic [29:0]     r_start_adr;
    logic            r_cpu_run;
    logic [7:0]      r_cnt;

    logic            w_accept;
    logic            w_is_ram;
    logic            w_adr_bad;
    logic            w_err;

    assign w_accept  = cmd_valid & r_cmd_ready;
    assign w_is_ram  = (cmd_op == OP_WRITE) | (cmd_op == OP_READ) | (cmd_op == OP_FILL);
    // Any word-address bit above the RAM size is out of range.
    assign w_adr_bad = |cmd_adr[29:AW];
    assign w_err     = (w_is_ram & (r_cpu_run | w_adr_bad))
                     | ((cmd_op == OP_RUN) & r_cpu_run)
                     | (cmd_op == OP_RSVD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_wen       <= 1'b0;
            r_wadr      <= '0;
            r_wdata     <= '0;
            r_read_sel  <= 1'b0;
            r_radr      <= '0;
            r_cpu_start <= 1'b0;
            r_start_adr <= '0;
            r_cpu_run   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        if (w_err) begin
                            r_state     <= S_RSP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            case (cmd_op)
                                OP_WRITE: begin
                                    r_wen   <= 1'b1;
                                    r_wadr  <= cmd_adr[AW-1:0];
                                    r_wdata <= cmd_data;
                                    r_state <= S_WR;
                                end
                                OP_READ: begin
                                    r_read_sel <= 1'b1;
                                    r_radr     <= cmd_adr[AW-1:0];
                                    r_state    <= S_RD_A;
                                end
                                OP_FILL: begin
                                    r_wen   <= 1'b1;
                                    r_wadr  <= cmd_adr[AW-1:0];
                                    r_wdata <= cmd_data;
                                    r_cnt   <= cmd_len;
                                    r_state <= S_FILL;
                                end
                                OP_RUN: begin
                                    // RUN reuses the one-cycle WR step to space the
                                    // start pulse and the response; no write is raised.
                                    r_cpu_start <= 1'b1;
                                    r_start_adr <= cmd_adr;
                                    r_cpu_run   <= 1'b1;
                                    r_state     <= S_WR;
                                end
                                OP_HALT: begin
                                    r_cpu_run   <= 1'b0;
                                    r_rsp_valid <= 1'b1;
                                    r_state     <= S_RSP;
                                end
                                OP_READPC: begin
                                    r_rsp_data  <= pc_data;
                                    r_rsp_valid <= 1'b1;
                                    r_state     <= S_RSP;
                                end
                                default: begin
                                    r_rsp_valid <= 1'b1;
                                    r_state     <= S_RSP;
                                end
                            endcase
                        end
                    end
                end
                S_WR: begin
                    r_wen       <= 1'b0;
                    r_cpu_start <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RSP;
                end
                S_FILL: begin
                    if (r_cnt == 8'd0) begin
                        r_wen       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end else begin
                        r_cnt  <= r_cnt - 8'd1;
                        // Address wraps naturally past the top of RAM.
                        r_wadr <= r_wadr + 1'b1;
                    end
                end
                S_RD_A: begin
                    r_state <= S_RD_D;
                end
                S_RD_D: begin
                    r_rsp_data  <= i_ram_rdata;
                    r_read_sel  <= 1'b0;
                    r_radr      <= '0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RSP;
                end
                S_RSP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;
    assign i_ram_wen   = r_wen;
    assign i_ram_wadr  = r_wadr;
    assign i_ram_wdata = r_wdata;
    assign i_read_sel  = r_read_sel;
    assign i_ram_radr  = r_radr;
    assign cpu_start   = r_cpu_start;
    assign start_adr   = r_start_adr;
    assign cpu_run     = r_cpu_run;

endmodule

// File: doc/iram_access_ctrl.md
Name: iram_access_ctrl

Overview:
- Command sequencer between the debug monitor (UART command parser) and the instruction-fetch stage.
- Serializes monitor commands into instruction-RAM write, read and fill sequences, and owns the i_read_sel steal of the fetch read port.
- Controls CPU run/halt, and launches execution through a cpu_start pulse with a start address.
- Blocks any RAM access while the CPU is running.

Parameters:
IWIDTH, 12, MSB of the instruction-RAM word address; RAM holds 2^(IWIDTH-1) words, addressed [IWIDTH:2].

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  3  0 NOP, 1 WRITE, 2 READ, 3 FILL, 4 RUN, 5 HALT, 6 READPC, 7 reserved
cmd_adr  input  30  word address [31:2]
cmd_data  input  32  write/fill data
cmd_len  input  8  FILL count minus one
rsp_valid  output  1  one-cycle response strobe
rsp_data  output  32  read data / PC value
rsp_err  output  1  command rejected (valid with rsp_valid)
i_ram_wen  output  1  instruction-RAM write enable
i_ram_wadr  output  IWIDTH-1  RAM write word address
i_ram_wdata  output  32  RAM write data
i_read_sel  output  1  monitor owns RAM read port
i_ram_radr  output  IWIDTH-1  RAM read word address
i_ram_rdata  input  32  RAM read data; valid the cycle after the address is presented
pc_data  input  32  current fetch PC (byte address)
cpu_start  output  1  one-cycle PC load strobe
start_adr  output  30  PC load value [31:2]
cpu_run  output  1  1 = CPU running; 0 drives the fetch stall

Behaviour:
- Reset (async, rst_n low):
  - state IDLE; cmd_ready=1.
  - All other outputs 0: rsp_valid, rsp_data, rsp_err, i_ram_wen, i_ram_wadr, i_ram_wdata, i_read_sel, i_ram_radr, cpu_start, start_adr, cpu_run.
  - Reset mid-sequence aborts it; no further RAM write occurs.
- Handshake:
  - cmd_ready=1 only in IDLE; accept on cmd_valid & cmd_ready at clock edge E0.
  - cmd_op, cmd_adr, cmd_data and cmd_len are registered at E0.
  - Exactly one rsp_valid pulse per accepted command, including NOP and reserved opcodes.
  - All response outputs are registered.
  - rsp_data holds its value until the next response.
- States: IDLE, WR, FILL, RD_A, RD_D, RSP.
- Error check at acceptance:
  - RAM op (WRITE/READ/FILL) with cpu_run=1 -> error.
  - RAM op with cmd_adr[31:IWIDTH+1] nonzero -> error.
  - RUN with cpu_run=1 -> error.
  - Reserved opcode -> error.
  - Erroring commands go IDLE -> RSP with rsp_err=1 and touch neither RAM nor CPU.
- WRITE: IDLE -> WR for 1 cycle (i_ram_wen=1, i_ram_wadr=adr, i_ram_wdata=data) -> RSP. rsp_valid is high 2 cycles after E0.
- READ:
  - RD_A: i_read_sel=1, i_ram_radr=adr.
  - RD_D: i_read_sel=1, capture i_ram_rdata into rsp_data.
  - Then RSP; rsp_valid is high 3 cycles after E0.
  - i_read_sel is 0 in every other state; i_ram_radr=0 when not selected.
- FILL:
  - Writes cmd_data to cmd_len+1 consecutive words starting at adr, one per cycle, i_ram_wen held high.
  - 8-bit down-counter; address counter increments modulo 2^(IWIDTH-1).
  - Wrap past top of RAM continues at word 0; this is not an error.
  - Leave FILL when the counter reaches 0; rsp_valid is high cmd_len+2 cycles after E0.
- RUN:
  - In the cycle after E0: cpu_start=1 for one cycle, start_adr=cmd_adr, cpu_run set to 1 (both visible in the same cycle).
  - rsp_valid follows one cycle later.
  - start_adr holds its value after the pulse.
- HALT: cpu_run cleared at the cycle after E0; rsp_valid that cycle. HALT while already halted is not an error.
- READPC: rsp_data=pc_data sampled at E0; rsp_valid one cycle after E0. Legal in any run state.
- NOP: rsp_valid one cycle after E0, rsp_err=0.
- RSP: rsp_valid=1 for one cycle, then IDLE. cmd_ready returns 1 in the cycle after rsp_valid.
- Never simultaneous: i_ram_wen with i_read_sel; cpu_run=1 with i_read_sel or i_ram_wen.

Test Plan:
- Reset, then WRITE adr=0x10 data=0xDEADBEEF -> exactly one cycle of i_ram_wen with wadr=0x10; rsp_valid at E0+2, rsp_err=0. Then READ adr=0x10 -> i_read_sel high 2 cycles; rsp_data=0xDEADBEEF at E0+3.
- FILL adr=2^(IWIDTH-1)-2, len=3, data=0x13 -> 4 writes at adr top-1, top, 0, 1 (wrap); rsp at E0+5. READ of each address returns 0x13.
- RUN adr=0x40 -> cpu_start one cycle with start_adr=0x40, cpu_run=1. A subsequent WRITE -> rsp_err=1 with no i_ram_wen. A second RUN -> rsp_err=1 with no cpu_start.
- While running, READPC -> rsp_data equals pc_data at acceptance. Then HALT -> cpu_run=0; a following READ succeeds.
- READ adr with bit IWIDTH+1 set, and opcode 7 -> rsp_err=1, no RAM access. Assert rst_n mid-FILL (len=200) -> writes stop immediately and all outputs return to 0.
